// File: rtl/frame_pingpong_ctrl_pkg.sv
// frame_pingpong_ctrl_pkg: image constants and controller state encoding shared
// by capture, color_proc and the ping-pong frame buffer controller.
package frame_pingpong_ctrl_pkg;
   localparam int c_img_cols = 160;
   localparam int c_img_rows = 120;
   localparam int c_img_pxls = c_img_cols * c_img_rows;
   localparam int c_nb_img_pxls = 15;
   localparam logic [c_nb_img_pxls-1:0] c_last_pxl = c_nb_img_pxls'(c_img_pxls - 1);
   typedef enum logic [1:0] {SYNC, FILL, FULL} state_t;
endpackage

// File: rtl/frame_pingpong_ctrl_if.sv
// frame_pingpong_ctrl_if: capture, processing and frame buffer signals of the
// ping-pong controller; slave is the controller side, master the surroundings.
interface frame_pingpong_ctrl_if;
   import frame_pingpong_ctrl_pkg::*;
   logic                     cap_we;
   logic [c_nb_img_pxls-1:0] cap_addr;
   logic [c_nb_img_pxls-1:0] proc_addr;
   logic                     proc_done;
   logic                     freeze;
   logic                     fb_we;
   logic [c_nb_img_pxls:0]   fb_wr_addr;
   logic [c_nb_img_pxls:0]   fb_rd_addr;
   logic                     proc_start;
   logic                     wr_bank;
   logic                     rd_bank;
   logic [7:0]               drop_cnt;
   modport slave (
      input  cap_we, cap_addr, proc_addr, proc_done, freeze,
      output fb_we, fb_wr_addr, fb_rd_addr, proc_start, wr_bank, rd_bank, drop_cnt
   );
   modport master (
      output cap_we, cap_addr, proc_addr, proc_done, freeze,
      input  fb_we, fb_wr_addr, fb_rd_addr, proc_start, wr_bank, rd_bank, drop_cnt
   );
endinterface

// File: rtl/frame_pingpong_ctrl_sat_counter.sv
// sat_counter: up counter with synchronous clear that holds at all-ones.
module sat_counter #(
   parameter int c_width = 8
) (
   input  logic               clk,
   input  logic               i_clr,
   input  logic               i_inc,
   output logic [c_width-1:0] o_q
);
   logic [c_width-1:0] r_q;
   always_ff @(posedge clk)
      r_q <= i_clr ? '0 : (i_inc && r_q != '1) ? r_q + 1'b1 : r_q;
   assign o_q = r_q;
endmodule

// File: rtl/frame_pingpong_ctrl.sv
// frame_pingpong_ctrl: steers capture writes and processing reads to opposite
// banks, swapping only on whole frames. FRAME_DROP_CNT_EN builds the drop counter.
module frame_pingpong_ctrl
   import frame_pingpong_ctrl_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   frame_pingpong_ctrl_if.slave bus
);
   state_t r_state, w_next;
   logic   r_wr_bank, r_rd_bank, r_busy, r_start;
   logic   w_sof, w_eof, w_hand, w_swap;
   assign w_sof  = bus.cap_we && bus.cap_addr == '0;
   assign w_eof  = bus.cap_we && bus.cap_addr == c_last_pxl;
   assign w_hand = !bus.freeze && (!r_busy || bus.proc_done);
   always_comb begin
      w_swap = w_hand && ((r_state == FILL && w_eof) || r_state == FULL);
      w_next = w_swap                     ? SYNC :
               (r_state == SYNC && w_sof) ? FILL :
               (r_state == FILL && w_eof) ? FULL : r_state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= SYNC;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b1;
         r_busy    <= 1'b0;
         r_start   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_start   <= w_swap;
         r_wr_bank <= r_wr_bank ^ w_swap;
         r_rd_bank <= r_rd_bank ^ w_swap;
         r_busy    <= w_swap || (r_busy && !bus.proc_done);
      end
   end
   // only the first pixel may open a frame from SYNC; out-of-frame addresses never write
   assign bus.fb_we      = bus.cap_we && bus.cap_addr <= c_last_pxl &&
                           (r_state == FILL || (r_state == SYNC && bus.cap_addr == '0));
   assign bus.fb_wr_addr = {r_wr_bank, bus.cap_addr};
   assign bus.fb_rd_addr = {r_rd_bank, bus.proc_addr};
   assign bus.proc_start = r_start;
   assign bus.wr_bank    = r_wr_bank;
   assign bus.rd_bank    = r_rd_bank;
`ifdef FRAME_DROP_CNT_EN
   logic [7:0] w_drop;
   sat_counter #(.c_width(8)) u_drop (
      .clk   (clk),
      .i_clr (rst),
      .i_inc (r_state == FULL && w_sof),
      .o_q   (w_drop)
   );
   assign bus.drop_cnt = w_drop;
`else
   assign bus.drop_cnt = '0;
`endif
endmodule
